// File: rtl/port_nic.sv
// port_nic: endpoint interface for one switch port. A TX FIFO feeds the validtx/acktx handshake and
// an RX FIFO collects flits from validrx/ackrx. Define PORT_NIC_STATS_EN to add 16-bit flit counters.
module port_nic #(
    parameter int DW    = 4,
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          usr_tx_valid_i,
    output logic          usr_tx_ready_o,
    input  logic [2:0]    usr_tx_adr_i,
    input  logic [DW-1:0] usr_tx_dat_i,
    output logic          validtx_o,
    output logic [2:0]    adr_o,
    output logic [DW-1:0] dat_o,
    input  logic          acktx_i,
    input  logic          validrx_i,
    input  logic [DW+2:0] dat_i,
    output logic          ackrx_o,
    output logic          usr_rx_valid_o,
    input  logic          usr_rx_ready_i,
    output logic [2:0]    usr_rx_adr_o,
    output logic [DW-1:0] usr_rx_dat_o
`ifdef PORT_NIC_STATS_EN
    ,
    output logic [15:0]   tx_cnt_o,
    output logic [15:0]   rx_cnt_o
`endif
);

    localparam int N = 2**DEPTH;
    localparam logic [DEPTH:0] C_FULL = {1'b1, {DEPTH{1'b0}}};

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_GAP = 2'd2} tx_state_t;
    typedef enum logic {RX_IDLE = 1'b0, RX_WAIT = 1'b1} rx_state_t;

    // TX FIFO
    logic [DW+2:0]  r_tx_mem [N];
    logic [DEPTH-1:0] r_tx_wp, r_tx_rp;
    logic [DEPTH:0] r_tx_cnt;
    logic           w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
    logic [DW+2:0]  w_tx_head;

    assign w_tx_full      = (r_tx_cnt == C_FULL);
    assign w_tx_empty     = (r_tx_cnt == '0);
    assign w_tx_push      = usr_tx_valid_i & ~w_tx_full;
    assign w_tx_head      = r_tx_mem[r_tx_rp];
    assign usr_tx_ready_o = ~w_tx_full;

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= {usr_tx_adr_i, usr_tx_dat_i};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // TX handshake FSM: the gap state forces one idle cycle between flits
    tx_state_t r_tx_state, w_tx_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (!w_tx_empty) w_tx_next = TX_REQ;
            TX_REQ: begin
                if (acktx_i) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = TX_GAP;
                end
            end
            TX_GAP:  w_tx_next = w_tx_empty ? TX_IDLE : TX_REQ;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    assign validtx_o = (r_tx_state == TX_REQ);
    assign adr_o     = validtx_o ? w_tx_head[DW+2:DW] : '0;
    assign dat_o     = validtx_o ? w_tx_head[DW-1:0]  : '0;

    // RX FIFO
    logic [DW+2:0]  r_rx_mem [N];
    logic [DEPTH-1:0] r_rx_wp, r_rx_rp;
    logic [DEPTH:0] r_rx_cnt;
    logic           w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic [DW+2:0]  w_rx_head;

    assign w_rx_full      = (r_rx_cnt == C_FULL);
    assign w_rx_empty     = (r_rx_cnt == '0);
    assign w_rx_pop       = ~w_rx_empty & usr_rx_ready_i;
    assign w_rx_head      = r_rx_mem[r_rx_rp];
    assign usr_rx_valid_o = ~w_rx_empty;
    assign usr_rx_adr_o   = w_rx_empty ? '0 : w_rx_head[DW+2:DW];
    assign usr_rx_dat_o   = w_rx_empty ? '0 : w_rx_head[DW-1:0];

    always_ff @(posedge clk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // RX FSM: after a capture, wait for validrx to drop so a held flit is not taken twice
    rx_state_t r_rx_state, w_rx_next;
    logic      r_ackrx;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rx_state <= RX_IDLE;
            r_ackrx    <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_ackrx    <= w_rx_push;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (validrx_i && !w_rx_full) begin
                    w_rx_push = 1'b1;
                    w_rx_next = RX_WAIT;
                end
            end
            RX_WAIT: if (!validrx_i) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    assign ackrx_o = r_ackrx;

`ifdef PORT_NIC_STATS_EN
    logic [15:0] r_tx_flits, r_rx_flits;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tx_flits <= '0;
            r_rx_flits <= '0;
        end else begin
            if (w_tx_pop)  r_tx_flits <= r_tx_flits + 1'b1;
            if (w_rx_push) r_rx_flits <= r_rx_flits + 1'b1;
        end
    end

    assign tx_cnt_o = r_tx_flits;
    assign rx_cnt_o = r_rx_flits;
`endif

endmodule

// File: tb/tb_port_nic.sv
// Testbench for port_nic: directed scenarios plus randomized TX and RX traffic against queue models.
`timescale 1ns/1ps
module tb_port_nic;
    localparam int DW = 4;
    localparam int FW = DW + 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          usr_tx_valid_i;
    logic          usr_tx_ready_o;
    logic [2:0]    usr_tx_adr_i;
    logic [DW-1:0] usr_tx_dat_i;
    logic          validtx_o;
    logic [2:0]    adr_o;
    logic [DW-1:0] dat_o;
    logic          acktx_i;
    logic          validrx_i;
    logic [FW-1:0] dat_i;
    logic          ackrx_o;
    logic          usr_rx_valid_o;
    logic          usr_rx_ready_i;
    logic [2:0]    usr_rx_adr_o;
    logic [DW-1:0] usr_rx_dat_o;
`ifdef PORT_NIC_STATS_EN
    logic [15:0]   tx_cnt_o;
    logic [15:0]   rx_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    port_nic #(.DW(DW), .DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .usr_tx_valid_i(usr_tx_valid_i), .usr_tx_ready_o(usr_tx_ready_o),
        .usr_tx_adr_i(usr_tx_adr_i), .usr_tx_dat_i(usr_tx_dat_i),
        .validtx_o(validtx_o), .adr_o(adr_o), .dat_o(dat_o), .acktx_i(acktx_i),
        .validrx_i(validrx_i), .dat_i(dat_i), .ackrx_o(ackrx_o),
        .usr_rx_valid_o(usr_rx_valid_o), .usr_rx_ready_i(usr_rx_ready_i),
        .usr_rx_adr_o(usr_rx_adr_o), .usr_rx_dat_o(usr_rx_dat_o)
`ifdef PORT_NIC_STATS_EN
        , .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        usr_tx_valid_i = 1'b0; usr_tx_adr_i = '0; usr_tx_dat_i = '0; acktx_i = 1'b0;
        validrx_i = 1'b0; dat_i = '0; usr_rx_ready_i = 1'b0;
        step; step;
        checks++;
        if ({validtx_o, ackrx_o, usr_rx_valid_o, usr_tx_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0001", {validtx_o, ackrx_o, usr_rx_valid_o, usr_tx_ready_o});
        end
        checks++;
        if ({adr_o, dat_o, usr_rx_adr_o, usr_rx_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {adr_o, dat_o, usr_rx_adr_o, usr_rx_dat_o});
        end
        rst_i = 1'b1;
        step;
        checks++;
        if (validtx_o !== 1'b0 || usr_tx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got v=%b r=%b exp v=0 r=1", validtx_o, usr_tx_ready_o);
        end
    endtask

    task automatic test_single_flit;
        usr_tx_valid_i = 1'b1; usr_tx_adr_i = 3'b101; usr_tx_dat_i = 4'hA;
        step;
        usr_tx_valid_i = 1'b0;
        checks++;
        if (validtx_o !== 1'b0) begin
            errors++; $display("FAIL single_early got %b exp 0", validtx_o);
        end
        for (int i = 0; i < 2; i++) begin
            step;
            checks++;
            if ({validtx_o, adr_o, dat_o} !== {1'b1, 3'b101, 4'hA}) begin
                errors++;
                $display("FAIL single_present%0d got %h exp da", i, {validtx_o, adr_o, dat_o});
            end
        end
        acktx_i = 1'b1;
        step;
        acktx_i = 1'b0;
        checks++;
        if (validtx_o !== 1'b0) begin
            errors++; $display("FAIL single_gap got %b exp 0", validtx_o);
        end
        step;
        checks++;
        if (validtx_o !== 1'b0 || usr_tx_ready_o !== 1'b1) begin
            errors++; $display("FAIL single_idle got v=%b r=%b exp v=0 r=1", validtx_o, usr_tx_ready_o);
        end
    endtask

    task automatic test_tx_fill;
        logic [FW-1:0] exp_f [4];
        for (int i = 0; i < 4; i++) begin
            exp_f[i] = {3'($urandom), 4'(i + 1)};
            usr_tx_valid_i = 1'b1;
            usr_tx_adr_i = exp_f[i][FW-1:DW];
            usr_tx_dat_i = exp_f[i][DW-1:0];
            step;
        end
        usr_tx_valid_i = 1'b0;
        checks++;
        if (usr_tx_ready_o !== 1'b0) begin
            errors++; $display("FAIL fill_full got ready=%b exp 0", usr_tx_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({validtx_o, adr_o, dat_o} !== {1'b1, exp_f[i]}) begin
                errors++;
                $display("FAIL fill_order%0d got %h exp %h", i, {validtx_o, adr_o, dat_o}, {1'b1, exp_f[i]});
            end
            acktx_i = 1'b1;
            step;
            acktx_i = 1'b0;
            checks++;
            if (validtx_o !== 1'b0 || usr_tx_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL fill_gap%0d got v=%b r=%b exp v=0 r=1", i, validtx_o, usr_tx_ready_o);
            end
            step;
        end
        checks++;
        if (validtx_o !== 1'b0) begin
            errors++; $display("FAIL fill_empty got %b exp 0", validtx_o);
        end
    endtask

    // TX traffic: presentation timing follows from whether a flit was shown, acked, and queued
    task automatic test_tx_random(input int ack_pct, input int ncyc);
        logic [FW-1:0] q[$];
        logic [FW-1:0] f;
        logic prev_v, prev_ne, popped, exp_v, push, ack;
        prev_v = 1'b0; prev_ne = 1'b0; popped = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            exp_v = prev_v ? ~popped : prev_ne;
            checks++;
            if (validtx_o !== exp_v) begin
                errors++; $display("FAIL txr_valid cyc %0d got %b exp %b", c, validtx_o, exp_v);
            end
            if (validtx_o === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL txr_head cyc %0d got %h exp nothing queued", c, {adr_o, dat_o});
                end else if ({adr_o, dat_o} !== q[0]) begin
                    errors++; $display("FAIL txr_head cyc %0d got %h exp %h", c, {adr_o, dat_o}, q[0]);
                end
            end
            checks++;
            if (usr_tx_ready_o !== (q.size() < 4)) begin
                errors++; $display("FAIL txr_ready cyc %0d got %b exp %0d", c, usr_tx_ready_o, q.size() < 4);
            end
            push = ($urandom_range(0, 99) < 60) && (q.size() < 4);
            f = FW'($urandom);
            usr_tx_valid_i = push;
            usr_tx_adr_i = f[FW-1:DW];
            usr_tx_dat_i = f[DW-1:0];
            ack = ($urandom_range(0, 99) < ack_pct);
            acktx_i = ack;
            prev_v = validtx_o;
            prev_ne = (q.size() != 0);
            step;
            popped = ack & prev_v;
            if (popped) void'(q.pop_front());
            if (push) q.push_back(f);
        end
        usr_tx_valid_i = 1'b0;
        acktx_i = 1'b1;
        repeat (12) step;
        acktx_i = 1'b0;
        step;
        checks++;
        if (validtx_o !== 1'b0 || usr_tx_ready_o !== 1'b1) begin
            errors++; $display("FAIL txr_drain got v=%b r=%b exp v=0 r=1", validtx_o, usr_tx_ready_o);
        end
    endtask

    task automatic test_rx_backpressure;
        logic [FW-1:0] fl [5];
        int acks;
        logic seen;
        usr_rx_ready_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            fl[i] = FW'($urandom);
            dat_i = fl[i];
            validrx_i = 1'b1;
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                step;
                if (ackrx_o === 1'b1) seen = 1'b1;
            end
            if (seen) acks++;
            if (i < 4) begin
                validrx_i = 1'b0;
                step;
            end
        end
        checks++;
        if (acks !== 4) begin
            errors++; $display("FAIL rxbp_acks got %0d exp 4", acks);
        end
        checks++;
        if ({usr_rx_valid_o, usr_rx_adr_o, usr_rx_dat_o} !== {1'b1, fl[0]}) begin
            errors++; $display("FAIL rxbp_head got %h exp %h", {usr_rx_valid_o, usr_rx_adr_o, usr_rx_dat_o}, {1'b1, fl[0]});
        end
        usr_rx_ready_i = 1'b1;
        step;
        usr_rx_ready_i = 1'b0;
        checks++;
        if (ackrx_o !== 1'b0) begin
            errors++; $display("FAIL rxbp_popcycle got ack=%b exp 0", ackrx_o);
        end
        seen = 1'b0;
        for (int w = 0; w < 2 && !seen; w++) begin
            step;
            if (ackrx_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL rxbp_late_ack got %b exp 1", seen);
        end
        validrx_i = 1'b0;
        step;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if ({usr_rx_valid_o, usr_rx_adr_o, usr_rx_dat_o} !== {1'b1, fl[i]}) begin
                errors++;
                $display("FAIL rxbp_order%0d got %h exp %h", i, {usr_rx_valid_o, usr_rx_adr_o, usr_rx_dat_o}, {1'b1, fl[i]});
            end
            usr_rx_ready_i = 1'b1;
            step;
            usr_rx_ready_i = 1'b0;
        end
        checks++;
        if (usr_rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL rxbp_empty got %b exp 0", usr_rx_valid_o);
        end
    endtask

    task automatic test_rx_held;
        logic [FW-1:0] f;
        int acks;
        f = FW'($urandom);
        dat_i = f;
        validrx_i = 1'b1;
        acks = 0;
        for (int w = 0; w < 4; w++) begin
            step;
            if (ackrx_o === 1'b1) acks++;
        end
        validrx_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            step;
            if (ackrx_o === 1'b1) acks++;
        end
        checks++;
        if (acks !== 1) begin
            errors++; $display("FAIL held_acks got %0d exp 1", acks);
        end
        checks++;
        if ({usr_rx_valid_o, usr_rx_adr_o, usr_rx_dat_o} !== {1'b1, f}) begin
            errors++; $display("FAIL held_head got %h exp %h", {usr_rx_valid_o, usr_rx_adr_o, usr_rx_dat_o}, {1'b1, f});
        end
        usr_rx_ready_i = 1'b1;
        step;
        usr_rx_ready_i = 1'b0;
        checks++;
        if (usr_rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL held_single got valid=%b exp 0", usr_rx_valid_o);
        end
    endtask

    // RX traffic: a switch that offers a flit, may keep validrx high after the ack, then drops it
    task automatic test_rx_random(input int ncyc);
        logic [FW-1:0] rq[$];
        logic [FW-1:0] f;
        logic pend, exp_ack, do_pop;
        int hold;
        pend = 1'b0; exp_ack = 1'b0; hold = 0;
        validrx_i = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if (ackrx_o !== exp_ack) begin
                errors++; $display("FAIL rxr_ack cyc %0d got %b exp %b", c, ackrx_o, exp_ack);
            end
            checks++;
            if (usr_rx_valid_o !== (rq.size() != 0)) begin
                errors++; $display("FAIL rxr_valid cyc %0d got %b exp %0d", c, usr_rx_valid_o, rq.size() != 0);
            end
            if (rq.size() != 0) begin
                checks++;
                if ({usr_rx_adr_o, usr_rx_dat_o} !== rq[0]) begin
                    errors++; $display("FAIL rxr_head cyc %0d got %h exp %h", c, {usr_rx_adr_o, usr_rx_dat_o}, rq[0]);
                end
            end
            if (ackrx_o === 1'b1) begin
                pend = 1'b0;
                hold = int'($urandom_range(0, 3));
            end
            if (!pend) begin
                if (hold > 0) hold--;
                else if (validrx_i) validrx_i = 1'b0;
                else if ($urandom_range(0, 1) == 1) begin
                    f = FW'($urandom);
                    dat_i = f;
                    validrx_i = 1'b1;
                    pend = 1'b1;
                end
            end
            usr_rx_ready_i = ($urandom_range(0, 99) < 35);
            exp_ack = pend && (rq.size() < 4);
            do_pop = usr_rx_ready_i && (rq.size() != 0);
            step;
            if (do_pop) void'(rq.pop_front());
            if (exp_ack) rq.push_back(dat_i);
        end
        validrx_i = 1'b0;
        usr_rx_ready_i = 1'b1;
        repeat (8) step;
        usr_rx_ready_i = 1'b0;
        checks++;
        if (usr_rx_valid_o !== 1'b0 || ackrx_o !== 1'b0) begin
            errors++; $display("FAIL rxr_drain got valid=%b ack=%b exp 0 0", usr_rx_valid_o, ackrx_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [FW-1:0] f;
        f = FW'($urandom);
        usr_tx_valid_i = 1'b1; usr_tx_adr_i = f[FW-1:DW]; usr_tx_dat_i = f[DW-1:0];
        step;
        f = FW'($urandom);
        usr_tx_adr_i = f[FW-1:DW]; usr_tx_dat_i = f[DW-1:0];
        validrx_i = 1'b1; dat_i = FW'($urandom);
        step;
        usr_tx_valid_i = 1'b0;
        validrx_i = 1'b0;
        checks++;
        if ({validtx_o, ackrx_o} !== 2'b11) begin
            errors++; $display("FAIL rstmid_pre got %b exp 11", {validtx_o, ackrx_o});
        end
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({validtx_o, ackrx_o, usr_rx_valid_o, usr_tx_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_async got %b exp 0001", {validtx_o, ackrx_o, usr_rx_valid_o, usr_tx_ready_o});
        end
        checks++;
        if ({adr_o, dat_o} !== '0) begin
            errors++; $display("FAIL rstmid_data got %h exp 0", {adr_o, dat_o});
        end
        step;
        rst_i = 1'b1;
        step; step;
        checks++;
        if ({validtx_o, usr_rx_valid_o, usr_tx_ready_o} !== 3'b001) begin
            errors++; $display("FAIL rstmid_after got %b exp 001", {validtx_o, usr_rx_valid_o, usr_tx_ready_o});
        end
`ifdef PORT_NIC_STATS_EN
        checks++;
        if ({tx_cnt_o, rx_cnt_o} !== 32'h0) begin
            errors++; $display("FAIL rstmid_stats got %h exp 0", {tx_cnt_o, rx_cnt_o});
        end
`endif
    endtask

    initial begin
        test_reset;
        test_single_flit;
        test_tx_fill;
        test_tx_random(100, 200);
        test_tx_random(50, 300);
        test_rx_backpressure;
        test_rx_held;
        test_rx_random(400);
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
